// File: rtl/supl_operand_loader_if.sv
// Handshake and operand bus between the byte-serial source, the operand loader
// and the downstream XOR/zero-index-sum unit.
interface supl_operand_loader_if #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
);
    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mode_en;
    logic              mode_sw;
    logic              abort;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              en;
    logic              sw;
    logic              out_valid;
    logic              out_ready;
    logic              frame_err;

    modport master (
        output in_data, in_valid, mode_en, mode_sw, abort, out_ready,
        input  in_ready, a, b, en, sw, out_valid, frame_err
    );

    modport slave (
        input  in_data, in_valid, mode_en, mode_sw, abort, out_ready,
        output in_ready, a, b, en, sw, out_valid, frame_err
    );
endinterface

// File: rtl/supl_operand_loader.sv
// Assembles operands a/b from a little-endian byte stream and presents them with a
// valid/ready handshake. Define FRAME_TIMEOUT_EN to drop stalled partial frames.
module supl_operand_loader #(
    parameter int WORD_W         = 32,
    parameter int BYTE_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                   clk,
    input logic                   rst,
    supl_operand_loader_if.slave  bus
);
    localparam int N     = WORD_W / BYTE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if ((WORD_W % BYTE_W) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("supl_operand_loader: WORD_W must be a multiple of BYTE_W, TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, PRESENT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] sh_a, sh_b, a_merge, b_merge;
    logic              sh_en, sh_sw;
    logic [WORD_W-1:0] a_q, b_q;
    logic              en_q, sw_q, out_valid_q, frame_err_q;
    logic              xfer;

`ifdef FRAME_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] idle_cnt;
`endif

    // in_ready is combinational on abort so an aborting cycle never accepts a byte
    assign bus.in_ready  = !rst && (state != PRESENT) && !bus.abort;
    assign xfer          = bus.in_valid && bus.in_ready;
    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.en        = en_q;
    assign bus.sw        = sw_q;
    assign bus.out_valid = out_valid_q;
    assign bus.frame_err = frame_err_q;

    always_comb begin
        a_merge = sh_a;
        b_merge = sh_b;
        a_merge[int'(cnt)*BYTE_W +: BYTE_W] = bus.in_data;
        b_merge[int'(cnt)*BYTE_W +: BYTE_W] = bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            sh_en       <= 1'b0;
            sh_sw       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            en_q        <= 1'b0;
            sw_q        <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            idle_cnt    <= '0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            if (bus.abort && state != PRESENT) begin
                // Stale shadow bytes are harmless: every byte is rewritten by the next frame
                frame_err_q <= (state != IDLE);
                state       <= IDLE;
                cnt         <= '0;
`ifdef FRAME_TIMEOUT_EN
                idle_cnt    <= '0;
`endif
            end else begin
                case (state)
                    IDLE: if (xfer) begin
                        sh_a  <= a_merge;
                        sh_en <= bus.mode_en;
                        sh_sw <= bus.mode_sw;
                        cnt   <= CNT_W'(1);
                        state <= LOAD_A;
                    end
                    LOAD_A: if (xfer) begin
                        sh_a <= a_merge;
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= LOAD_B;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    LOAD_B: if (xfer) begin
                        sh_b <= b_merge;
                        if (cnt == CNT_LAST) begin
                            cnt         <= '0;
                            a_q         <= sh_a;
                            b_q         <= b_merge;
                            en_q        <= sh_en;
                            sw_q        <= sh_sw;
                            out_valid_q <= 1'b1;
                            state       <= PRESENT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PRESENT: if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
`ifdef FRAME_TIMEOUT_EN
                if (state == LOAD_A || state == LOAD_B) begin
                    if (xfer) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TO_LAST) begin
                        idle_cnt    <= '0;
                        cnt         <= '0;
                        frame_err_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + TO_W'(1);
                    end
                end
`endif
            end
        end
    end
endmodule
